// File: rtl/irq_ctrl.sv
// Interrupt controller: per-line edge/level capture, masking, fixed-priority
// arbitration, request/take/ack handshake and mtvec-based trap target.
module irq_ctrl #(
  parameter int          NUM_IRQ   = 32,
  parameter int          ID_W      = $clog2(NUM_IRQ),
  parameter logic [31:0] EDGE_MASK = 32'h0000_0000,
  parameter int          ADDR_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  input  logic               mie_i,
  input  logic               mtvec_mode_i,
  input  logic [ADDR_W-1:0]  mtvec_base_i,
  input  logic               irq_take_i,
  input  logic               mret_i,
  output logic               irq_req_o,
  output logic [ID_W-1:0]    irq_id_o,
  output logic               irq_ack_o,
  output logic [ADDR_W-1:0]  irq_target_o,
  output logic [NUM_IRQ-1:0] irq_pending_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2,
    ST_BUSY = 2'd3
  } state_e;

  state_e             state_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] pending_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] eligible_s;
  logic [ID_W-1:0]    winner_s;
  logic [ID_W-1:0]    id_q;
  logic               req_q;
  logic               ack_q;
  logic [ADDR_W-1:0]  base_al_s;
  logic [ADDR_W-1:0]  offset_s;
  logic               unused_base_s;

  // Next pending vector: edge lines latch until acked (a new edge beats the clear).
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (EDGE_MASK[i]) begin
        if (irq_i[i] && !irq_prev_q[i]) begin
          pending_d[i] = 1'b1;
        end else if ((state_q == ST_ACK) && (id_q == ID_W'(i))) begin
          pending_d[i] = 1'b0;
        end else begin
          pending_d[i] = pending_q[i];
        end
      end else begin
        pending_d[i] = irq_i[i];
      end
    end
  end

  // Eligible lines and highest-index winner.
  always_comb begin
    if (mie_i) begin
      eligible_s = pending_q & irq_mask_i;
    end else begin
      eligible_s = {NUM_IRQ{1'b0}};
    end
    winner_s = {ID_W{1'b0}};
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (eligible_s[i]) begin
        winner_s = ID_W'(i);
      end else begin
        winner_s = winner_s;
      end
    end
  end

  // Pending and edge-history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= {NUM_IRQ{1'b0}};
      irq_prev_q <= {NUM_IRQ{1'b0}};
    end else begin
      pending_q  <= pending_d;
      irq_prev_q <= irq_i;
    end
  end

  // Handshake FSM with registered req/ack/id; a take wins over a same-cycle withdrawal.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      id_q    <= {ID_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|eligible_s) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            id_q    <= winner_s;
          end
        end
        ST_REQ: begin
          if (irq_take_i) begin
            state_q <= ST_ACK;
            req_q   <= 1'b0;
            ack_q   <= 1'b1;
          end else if (!(|eligible_s)) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end else begin
            id_q    <= winner_s;
          end
        end
        ST_ACK: begin
          ack_q   <= 1'b0;
          state_q <= ST_BUSY;
        end
        ST_BUSY: begin
          if (mret_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign base_al_s     = {mtvec_base_i[ADDR_W-1:2], 2'b00};
  assign offset_s      = {{(ADDR_W-ID_W-2){1'b0}}, id_q, 2'b00};
  assign unused_base_s = ^mtvec_base_i[1:0];

  assign irq_target_o  = mtvec_mode_i ? (base_al_s + offset_s) : base_al_s;
  assign irq_req_o     = req_q;
  assign irq_ack_o     = ack_q;
  assign irq_id_o      = id_q;
  assign irq_pending_o = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomized and directed checks of irq_ctrl against a transaction-level model.
module tb_irq_ctrl;

  localparam logic [31:0] EMASK = 32'hF0F0_0028;  // edge lines 3,5,20-23,28-31

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] irq, mask, base, target, pend;
  logic        mie, mode, take, mret;
  logic        req, ack;
  logic [4:0]  id;

  int total = 0;
  int bad   = 0;

  // model state
  logic [31:0] m_pend, m_prev;
  bit          m_req, m_ack, m_wait;
  int          m_id;

  irq_ctrl #(.NUM_IRQ(32), .EDGE_MASK(EMASK), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .irq_i(irq), .irq_mask_i(mask), .mie_i(mie),
    .mtvec_mode_i(mode), .mtvec_base_i(base), .irq_take_i(take), .mret_i(mret),
    .irq_req_o(req), .irq_id_o(id), .irq_ack_o(ack), .irq_target_o(target),
    .irq_pending_o(pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the spec rules: pending capture, then handshake progress.
  task automatic model_step();
    logic [31:0] elig, np;
    int hi;
    if (rst) begin
      m_pend = 32'd0; m_prev = 32'd0;
      m_req = 1'b0; m_ack = 1'b0; m_wait = 1'b0; m_id = 0;
      return;
    end
    elig = mie ? (m_pend & mask) : 32'd0;
    hi = -1;
    for (int i = 31; i >= 0; i--) if (elig[i] && hi < 0) hi = i;
    for (int i = 0; i < 32; i++) begin
      if (EMASK[i])
        np[i] = (irq[i] && !m_prev[i]) || (m_pend[i] && !(m_ack && m_id == i));
      else
        np[i] = irq[i];
    end
    if (m_ack) begin
      m_ack = 1'b0; m_wait = 1'b1;
    end else if (m_wait) begin
      if (mret) m_wait = 1'b0;
    end else if (m_req) begin
      if (take) begin m_req = 1'b0; m_ack = 1'b1; end
      else if (hi < 0) m_req = 1'b0;
      else m_id = hi;
    end else if (hi >= 0) begin
      m_req = 1'b1; m_id = hi;
    end
    m_pend = np;
    m_prev = irq;
  endtask

  task automatic compare_all();
    logic [31:0] et;
    et = (base & 32'hFFFF_FFFC) + (mode ? 32'(m_id * 4) : 32'd0);
    chk("m_req", 64'(req), 64'(m_req));
    chk("m_ack", 64'(ack), 64'(m_ack));
    chk("m_id", 64'(id), 64'(m_id));
    chk("m_target", 64'(target), 64'(et));
    chk("m_pending", 64'(pend), 64'(m_pend));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst = 1'b1; irq = 32'd0; mask = 32'hFFFF_FFFF; base = 32'd0;
    mie = 1'b1; mode = 1'b0; take = 1'b0; mret = 1'b0;
    m_pend = 32'd0; m_prev = 32'd0; m_req = 1'b0; m_ack = 1'b0; m_wait = 1'b0; m_id = 0;
    ticks(2);
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_pend", 64'(pend), 64'd0);
    rst = 1'b0;

    // direct mode, edge line 3
    base = 32'h0000_1000;
    irq[3] = 1'b1; tick(); irq[3] = 1'b0;
    chk("t1_req_early", 64'(req), 64'd0);
    tick();
    chk("t1_req", 64'(req), 64'd1);
    chk("t1_id", 64'(id), 64'd3);
    take = 1'b1; tick(); take = 1'b0;
    chk("t1_ack", 64'(ack), 64'd1);
    chk("t1_ack_id", 64'(id), 64'd3);
    chk("t1_target", 64'(target), 64'h0000_1000);
    tick();
    chk("t1_ack_once", 64'(ack), 64'd0);
    chk("t1_pend3", 64'(pend[3]), 64'd0);
    mret = 1'b1; tick(); mret = 1'b0; tick();

    // vectored mode, level line 11
    mode = 1'b1; base = 32'h8000_0001; irq[11] = 1'b1;
    ticks(2);
    chk("t2_id", 64'(id), 64'd11);
    chk("t2_target", 64'(target), 64'h8000_002C);
    take = 1'b1; tick(); take = 1'b0;
    chk("t2_ack", 64'(ack), 64'd1);
    ticks(3);
    chk("t2_no_nest", 64'(req), 64'd0);
    mret = 1'b1; tick(); mret = 1'b0; tick();
    chk("t2_rereq", 64'(req), 64'd1);
    chk("t2_reid", 64'(id), 64'd11);
    take = 1'b1; tick(); take = 1'b0; tick();
    irq[11] = 1'b0; mret = 1'b1; tick(); mret = 1'b0; tick();

    // simultaneous 5 and 20
    irq[5] = 1'b1; irq[20] = 1'b1; tick(); irq[5] = 1'b0; irq[20] = 1'b0; tick();
    chk("t3_id20", 64'(id), 64'd20);
    take = 1'b1; tick(); take = 1'b0;
    chk("t3_ack_id", 64'(id), 64'd20);
    tick(); mret = 1'b1; tick(); mret = 1'b0; tick();
    chk("t3_id5", 64'(id), 64'd5);
    chk("t3_req5", 64'(req), 64'd1);
    take = 1'b1; tick(); take = 1'b0; tick(); mret = 1'b1; tick(); mret = 1'b0; tick();

    // preemption in REQ
    irq[5] = 1'b1; tick(); irq[5] = 1'b0; tick();
    chk("t4_id5", 64'(id), 64'd5);
    irq[20] = 1'b1; tick(); irq[20] = 1'b0; tick();
    chk("t4_id20", 64'(id), 64'd20);
    take = 1'b1; tick(); take = 1'b0;
    chk("t4_ack20", 64'(id), 64'd20);
    tick(); mret = 1'b1; tick(); mret = 1'b0; tick();
    take = 1'b1; tick(); take = 1'b0; tick(); mret = 1'b1; tick(); mret = 1'b0; tick();

    // withdrawal by mie
    irq[7] = 1'b1; ticks(2);
    chk("t5_id7", 64'(id), 64'd7);
    mie = 1'b0; tick();
    chk("t5_wd_req", 64'(req), 64'd0);
    chk("t5_wd_ack", 64'(ack), 64'd0);
    mie = 1'b1; ticks(2);
    chk("t5_re_req", 64'(req), 64'd1);
    chk("t5_re_id", 64'(id), 64'd7);
    irq[7] = 1'b0; tick(); tick();

    // edge coinciding with its own ack clear
    irq[3] = 1'b1; tick(); irq[3] = 1'b0; tick();
    take = 1'b1; tick(); take = 1'b0;
    irq[3] = 1'b1; tick(); irq[3] = 1'b0;
    chk("t6_set_wins", 64'(pend[3]), 64'd1);

    // reset in BUSY, then in ACK
    base = 32'd0; irq[22] = 1'b1; tick(); irq[22] = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_busy_pend", 64'(pend), 64'd0);
    chk("t6_rst_busy_id", 64'(id), 64'd0);
    irq[21] = 1'b1; tick(); irq[21] = 1'b0; tick();
    take = 1'b1; tick(); take = 1'b0;
    chk("t6_in_ack", 64'(ack), 64'd1);
    irq[30] = 1'b1; rst = 1'b1; tick(); rst = 1'b0; irq[30] = 1'b0;
    chk("t6_rst_ack_ack", 64'(ack), 64'd0);
    chk("t6_rst_ack_req", 64'(req), 64'd0);
    chk("t6_rst_ack_pend", 64'(pend), 64'd0);
    chk("t6_rst_ack_tgt", 64'(target), 64'd0);
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      irq  = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 19) == 0) mask = $urandom | $urandom;
      mie  = ($urandom_range(0, 9) != 0);
      mode = $urandom_range(0, 1) == 1;
      base = $urandom;
      take = ($urandom_range(0, 2) == 0);
      mret = ($urandom_range(0, 4) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
